// File: rtl/mem_stage_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | mem_stage_ctrl_pkg: shared FSM encoding and M-bit indices. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;
  localparam int TIMEOUT_DEF = 64;

  function automatic logic is_access(input logic [1:0] m);
    return m[M_READ] | m[M_WRITE];
  endfunction

  // Both bits set is undefined in the ISA; it is executed as a store and flagged.
  function automatic logic is_illegal(input logic [1:0] m);
    return m[M_READ] & m[M_WRITE];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_wait_timer.sv
// +--------------------------------------------------------------------+
// | mem_wait_timer: WAIT-cycle counter with timeout compare. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count equals the index of the current WAIT cycle, so this flags the last allowed one.
  assign expired_o = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// +--------------------------------------------------------------------+
// | mem_stage_ctrl: MEM-stage req/ack access controller. Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        m_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              access;
  logic              stall;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_expired;

  assign access = is_access(m_i);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    stall      = 1'b0;
    tmr_clear  = 1'b1;
    tmr_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = access;
        if (access) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = m_i[M_WRITE];
          addr_d  = addr_i;
          wdata_d = wdata_i;
          if (is_illegal(m_i)) begin
            err_d = 1'b1;
          end
        end
      end

      WAIT: begin
        stall     = 1'b1;
        tmr_clear = 1'b0;
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d = mem_rdata_i;
            valid_d = 1'b1;
          end
        end else if (tmr_expired) begin
          // Abort: a dead load returns zero so MEM/WB never sees stale data.
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          tmr_enable = 1'b1;
        end
      end

      // EX/MEM still shows the finished request here; it is deliberately not sampled.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Gated by reset so a request still held in EX/MEM cannot stall during reset.
  assign stall_o       = rst_i & stall;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = valid_q;
  assign err_o         = err_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_mem_stage_ctrl: self-checking bench for mem_stage_ctrl. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [1:0]    m_i = 2'b00;
  logic [DW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          rdata_valid_o;
  logic          err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  int total = 0;
  int bad   = 0;

  // Transaction-level model of what software-visible state should be.
  logic [DW-1:0] model_rdata = '0;
  logic          model_err   = 1'b0;

  typedef struct {
    int            stall_cyc;
    int            req_cyc;
    int            req_rises;
    int            req_start;
    int            valid_pulses;
    bit            valid_done;
    bit            valid_after;
    logic [DW-1:0] rdata_done;
    logic          we_seen;
    logic [DW-1:0] addr_seen;
    logic [DW-1:0] wdata_seen;
    bit            unstable;
    bit            hung;
  } obs_t;

  mem_stage_ctrl #(
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .CNT_W   (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m_i           (m_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, got no finish want finish");
    $fatal(1);
  end

  // Plays one EX/MEM instruction: holds m_i while stalled, acts as memory acking on
  // WAIT cycle ack_at (0 = never), and records what it saw. Starts and ends 1ns after an edge.
  task automatic play(input logic [1:0] m, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rd, input int ack_at, input bit noise, output obs_t o);
    int  wait_cnt = 0;
    bit  done = 0;
    bit  prev_req = 0;
    o = '{default: 0};
    o.req_start = -1;
    m_i = m; addr_i = addr; wdata_i = wdata;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (mem_req_o) begin
        wait_cnt++;
        o.req_cyc++;
        if (!prev_req) o.req_rises++;
        if (o.req_start < 0) begin
          o.req_start  = cyc;
          o.we_seen    = mem_we_o;
          o.addr_seen  = mem_addr_o;
          o.wdata_seen = mem_wdata_o;
        end else if (mem_we_o !== o.we_seen || mem_addr_o !== o.addr_seen ||
                     mem_wdata_o !== o.wdata_seen) begin
          o.unstable = 1;
        end
        mem_ack_i   = (wait_cnt == ack_at);
        mem_rdata_i = (wait_cnt == ack_at) ? rd : DW'($urandom);
      end else begin
        mem_ack_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = DW'($urandom);
      end
      prev_req = mem_req_o;
      if (rdata_valid_o) o.valid_pulses++;
      if (stall_o) begin
        o.stall_cyc++;
      end else begin
        o.rdata_done = rdata_o;
        o.valid_done = rdata_valid_o;
        done = 1;
      end
      @(posedge clk_i); #1;
      if (done) break;
    end
    o.hung = !done;
    m_i = 2'b00; mem_ack_i = 1'b0;
    o.valid_after = rdata_valid_o;
  endtask

  // Spec-level expectation for one instruction; also advances the model.
  task automatic predict(input logic [1:0] m, input logic [DW-1:0] rd, input int ack_at,
                         output int e_stall, output int e_req, output bit e_valid);
    bit acked = (ack_at >= 1) && (ack_at <= TO);
    int w = acked ? ack_at : TO;
    if (m == 2'b00) begin
      e_stall = 0; e_req = 0; e_valid = 0;
    end else begin
      e_stall = 1 + w; e_req = w;
      e_valid = (m == 2'b10) && acked;
      if (m == 2'b10) model_rdata = acked ? rd : '0;
      if (m == 2'b11 || !acked) model_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; m_i = 2'b10;
    repeat (3) @(posedge clk_i);
    #1;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
    total++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
      bad++; $display("FAIL reset_req: got req=%0b we=%0b want 0 0", mem_req_o, mem_we_o);
    end
    total++;
    if ({rdata_o, mem_addr_o, mem_wdata_o} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h want zeros", rdata_o, mem_addr_o, mem_wdata_o);
    end
    total++;
    if (rdata_valid_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got valid=%0b err=%0b want 0 0", rdata_valid_o, err_o);
    end
    total++;
    m_i = 2'b00;
    rst_i = 1'b1;
    model_rdata = '0; model_err = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_load();
    obs_t o;
    int es, er; bit ev;
    predict(2'b10, 32'h1234ABCD, 3, es, er, ev);
    play(2'b10, 32'h40, 32'h0, 32'h1234ABCD, 3, 1'b0, o);
    if (o.hung || o.stall_cyc !== 4) begin bad++; $display("FAIL load_stall: got %0d want 4", o.stall_cyc); end
    total++;
    if (o.we_seen !== 1'b0 || o.addr_seen !== 32'h40) begin
      bad++; $display("FAIL load_req: got we=%0b addr=%h want 0 00000040", o.we_seen, o.addr_seen);
    end
    total++;
    if (o.rdata_done !== 32'h1234ABCD || !o.valid_done || o.valid_pulses != 1 || o.valid_after) begin
      bad++; $display("FAIL load_data: got rdata=%h valid_done=%0b pulses=%0d after=%0b want 1234abcd 1 1 0",
                      o.rdata_done, o.valid_done, o.valid_pulses, o.valid_after);
    end
    total++;
    if (o.req_cyc != er) begin bad++; $display("FAIL load_reqcyc: got %0d want %0d", o.req_cyc, er); end
    total++;
  endtask

  task automatic test_store();
    obs_t o;
    int es, er; bit ev;
    predict(2'b01, 32'h0, 1, es, er, ev);
    play(2'b01, 32'h80, 32'hCAFEF00D, 32'hDEADBEEF, 1, 1'b0, o);
    if (o.hung || o.stall_cyc !== 2) begin bad++; $display("FAIL store_stall: got %0d want 2", o.stall_cyc); end
    total++;
    if (o.we_seen !== 1'b1 || o.addr_seen !== 32'h80 || o.wdata_seen !== 32'hCAFEF00D) begin
      bad++; $display("FAIL store_req: got we=%0b addr=%h wdata=%h want 1 00000080 cafef00d",
                      o.we_seen, o.addr_seen, o.wdata_seen);
    end
    total++;
    if (o.valid_pulses != 0 || o.rdata_done !== model_rdata) begin
      bad++; $display("FAIL store_rdata: got pulses=%0d rdata=%h want 0 %h", o.valid_pulses, o.rdata_done, model_rdata);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    obs_t a, b;
    int es, er; bit ev;
    predict(2'b10, 32'h5555AAAA, 1, es, er, ev);
    play(2'b10, 32'h100, 32'h0, 32'h5555AAAA, 1, 1'b1, a);
    predict(2'b01, 32'h0, 2, es, er, ev);
    play(2'b01, 32'h104, 32'h77, 32'h0, 2, 1'b1, b);
    if (a.req_rises != 1 || b.req_rises != 1 || a.req_cyc != 1 || b.req_cyc != 2) begin
      bad++; $display("FAIL b2b_reqs: got rises=%0d,%0d cycles=%0d,%0d want 1,1 1,2",
                      a.req_rises, b.req_rises, a.req_cyc, b.req_cyc);
    end
    total++;
    if (b.req_start != 1 || b.stall_cyc != 3) begin
      bad++; $display("FAIL b2b_timing: got start=%0d stall=%0d want 1 3", b.req_start, b.stall_cyc);
    end
    total++;
    if (a.rdata_done !== 32'h5555AAAA || b.rdata_done !== model_rdata || b.valid_pulses != 0) begin
      bad++; $display("FAIL b2b_data: got %h %h pulses=%0d want 5555aaaa %h 0",
                      a.rdata_done, b.rdata_done, b.valid_pulses, model_rdata);
    end
    total++;
  endtask

  task automatic test_timeout();
    obs_t o;
    int es, er; bit ev;
    predict(2'b10, 32'hFFFFFFFF, 0, es, er, ev);
    play(2'b10, 32'h200, 32'h0, 32'hFFFFFFFF, 0, 1'b0, o);
    if (o.hung || o.req_cyc != TO || o.stall_cyc != TO + 1) begin
      bad++; $display("FAIL timeout_len: got req=%0d stall=%0d want %0d %0d", o.req_cyc, o.stall_cyc, TO, TO + 1);
    end
    total++;
    if (o.rdata_done !== '0 || o.valid_pulses != 0 || err_o !== 1'b1) begin
      bad++; $display("FAIL timeout_abort: got rdata=%h pulses=%0d err=%0b want 0 0 1",
                      o.rdata_done, o.valid_pulses, err_o);
    end
    total++;
    predict(2'b10, 32'h0BADF00D, 2, es, er, ev);
    play(2'b10, 32'h204, 32'h0, 32'h0BADF00D, 2, 1'b0, o);
    if (o.rdata_done !== 32'h0BADF00D || !o.valid_done || err_o !== 1'b1 || o.stall_cyc != 3) begin
      bad++; $display("FAIL timeout_after: got rdata=%h valid=%0b err=%0b stall=%0d want 0badf00d 1 1 3",
                      o.rdata_done, o.valid_done, err_o, o.stall_cyc);
    end
    total++;
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    m_i = 2'b10; addr_i = 32'h300;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got req=%0b want 1", mem_req_o); end
    total++;
    #2 rst_i = 1'b0;
    #1;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop: got req=%0b stall=%0b err=%0b want 0 0 0", mem_req_o, stall_o, err_o);
    end
    total++;
    m_i = 2'b00;
    model_rdata = '0; model_err = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (rdata_valid_o || mem_req_o || stall_o) seen++;
    end
    mem_ack_i = 1'b0;
    if (seen != 0 || rdata_o !== '0) begin
      bad++; $display("FAIL rstmid_late_ack: got activity=%0d rdata=%h want 0 0", seen, rdata_o);
    end
    total++;
  endtask

  task automatic test_random();
    obs_t o;
    int es, er; bit ev;
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 15);
      int a = $urandom_range(0, 9);
      logic [1:0]    m  = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : (r < 10) ? 2'b10 : 2'b01;
      logic [DW-1:0] ad = DW'($urandom);
      logic [DW-1:0] wd = DW'($urandom);
      logic [DW-1:0] rd = DW'($urandom);
      predict(m, rd, a, es, er, ev);
      play(m, ad, wd, rd, a, 1'b1, o);
      if (o.hung || o.stall_cyc != es || o.req_cyc != er || o.req_rises != (m != 0)) begin
        bad++; $display("FAIL rand_timing[%0d]: got stall=%0d req=%0d rises=%0d want %0d %0d %0d",
                        n, o.stall_cyc, o.req_cyc, o.req_rises, es, er, (m != 0));
      end
      total++;
      if (m != 2'b00 && (o.unstable || o.we_seen !== m[0] || o.addr_seen !== ad || o.wdata_seen !== wd)) begin
        bad++; $display("FAIL rand_req[%0d]: got we=%0b addr=%h wdata=%h unstable=%0b want %0b %h %h 0",
                        n, o.we_seen, o.addr_seen, o.wdata_seen, o.unstable, m[0], ad, wd);
      end
      total++;
      if (o.valid_done != ev || o.valid_pulses != int'(ev) || o.valid_after || o.rdata_done !== model_rdata) begin
        bad++; $display("FAIL rand_data[%0d]: got valid=%0b pulses=%0d rdata=%h want %0b %0d %h",
                        n, o.valid_done, o.valid_pulses, o.rdata_done, ev, int'(ev), model_rdata);
      end
      total++;
      if (err_o !== model_err) begin
        bad++; $display("FAIL rand_err[%0d]: got %0b want %0b", n, err_o, model_err);
      end
      total++;
    end
  endtask

  task automatic test_nop_and_illegal();
    obs_t o;
    int es, er; bit ev;
    int active = 0;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_rdata = '0; model_err = 1'b0;
    m_i = 2'b00;
    for (int i = 0; i < 20; i++) begin
      mem_ack_i = 1'(i & 1);
      addr_i = DW'($urandom);
      #1;
      if (stall_o || mem_req_o || rdata_valid_o) active++;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
    if (active != 0 || err_o !== 1'b0) begin
      bad++; $display("FAIL nop_stream: got active=%0d err=%0b want 0 0", active, err_o);
    end
    total++;
    predict(2'b11, 32'h0, 2, es, er, ev);
    play(2'b11, 32'h400, 32'h13572468, 32'h11111111, 2, 1'b0, o);
    if (o.we_seen !== 1'b1 || o.wdata_seen !== 32'h13572468 || o.stall_cyc != es || o.valid_pulses != 0) begin
      bad++; $display("FAIL illegal_write: got we=%0b wdata=%h stall=%0d pulses=%0d want 1 13572468 %0d 0",
                      o.we_seen, o.wdata_seen, o.stall_cyc, es, o.valid_pulses);
    end
    total++;
    if (err_o !== 1'b1 || o.rdata_done !== model_rdata) begin
      bad++; $display("FAIL illegal_err: got err=%0b rdata=%h want 1 %h", err_o, o.rdata_done, model_rdata);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_nop_and_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
